// File: rtl/coin_intake_pkg.sv
// Shared state encoding and default timing for the coin intake front end.
package coin_intake_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t SETUP    = 3'd1;
  localparam state_t STEP     = 3'd2;
  localparam state_t HOLD     = 3'd3;
  localparam state_t WAIT_REL = 3'd4;

  // 20 ms at 50 MHz
  localparam int unsigned DEF_DEB_CYCLES   = 1000000;
  localparam int unsigned DEF_SETUP_CYCLES = 4;
  localparam int unsigned DEF_PULSE_CYCLES = 8;
  localparam int unsigned DEF_HOLD_CYCLES  = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debounce counter; the clean level follows the
// synchronized input only after DEB_CYCLES consecutive samples disagree with it.
module sync_debounce import coin_intake_pkg::*; #(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic CLK50M,
  input  logic RES,
  input  logic din,
  output logic clean
);

  localparam int unsigned CW = $clog2(DEB_CYCLES) + 1;

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK50M or negedge RES) begin
    if (!RES) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // A sample matching the current clean level breaks any run toward the other level
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        clean <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_intake.sv
// Coin slot front end: debounces the two slot switches and presents one coin code per
// insertion to the vending FSM with setup/strobe/hold timing on CLKb.
module coin_intake import coin_intake_pkg::*; #(
  parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic       CLK50M,
  input  logic       RES,
  input  logic       Q_noisy,
  input  logic       H_noisy,
  output logic       Q,
  output logic       H,
  output logic       CLKb,
  output logic       busy,
  output logic       reject,
  output logic [7:0] coin_count
);

  localparam int unsigned TW = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES)) + 1;

  logic          q_clean, h_clean;
  logic          q_prev, h_prev;
  logic          q_ev, h_ev;
  state_t        state;
  logic [TW-1:0] tmr;

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_q (
    .CLK50M(CLK50M),
    .RES   (RES),
    .din   (Q_noisy),
    .clean (q_clean)
  );

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_h (
    .CLK50M(CLK50M),
    .RES   (RES),
    .din   (H_noisy),
    .clean (h_clean)
  );

  assign q_ev = q_clean & ~q_prev;
  assign h_ev = h_clean & ~h_prev;

  always_ff @(posedge CLK50M or negedge RES) begin
    if (!RES) begin
      state      <= IDLE;
      tmr        <= '0;
      q_prev     <= 1'b0;
      h_prev     <= 1'b0;
      Q          <= 1'b0;
      H          <= 1'b0;
      CLKb       <= 1'b1;
      busy       <= 1'b0;
      reject     <= 1'b0;
      coin_count <= 8'd0;
    end else begin
      q_prev <= q_clean;
      h_prev <= h_clean;
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (q_ev && h_ev) begin
            reject <= 1'b1;
            busy   <= 1'b1;
            state  <= WAIT_REL;
          end else if (q_ev || h_ev) begin
            Q     <= q_ev;
            H     <= h_ev;
            busy  <= 1'b1;
            tmr   <= TW'(SETUP_CYCLES - 1);
            state <= SETUP;
          end
        end
        SETUP: begin
          if (tmr == '0) begin
            CLKb  <= 1'b0;
            tmr   <= TW'(PULSE_CYCLES - 1);
            state <= STEP;
            if (coin_count != 8'hff) coin_count <= coin_count + 8'd1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        STEP: begin
          if (tmr == '0) begin
            CLKb  <= 1'b1;
            tmr   <= TW'(HOLD_CYCLES - 1);
            state <= HOLD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        HOLD: begin
          if (tmr == '0) begin
            Q     <= 1'b0;
            H     <= 1'b0;
            state <= WAIT_REL;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        WAIT_REL: begin
          if (!q_clean && !h_clean) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_intake.sv
// Bench for coin_intake: transaction-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_coin_intake;

  localparam int unsigned DEB = 4;
  localparam int unsigned S   = 2;
  localparam int unsigned P   = 3;
  localparam int unsigned HD  = 2;
  localparam int          TXN = S + P + HD;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       q_in  = 1'b0;
  logic       h_in  = 1'b0;
  logic       Q, H, CLKb, busy, reject;
  logic [7:0] coin_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  coin_intake #(
    .DEB_CYCLES  (DEB),
    .SETUP_CYCLES(S),
    .PULSE_CYCLES(P),
    .HOLD_CYCLES (HD)
  ) dut (
    .CLK50M    (clk),
    .RES       (rst_n),
    .Q_noisy   (q_in),
    .H_noisy   (h_in),
    .Q         (Q),
    .H         (H),
    .CLKb      (CLKb),
    .busy      (busy),
    .reject    (reject),
    .coin_count(coin_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: clean level = raw level once it has been constant over the DEB
  // samples seen through the two-stage sync; an accepted coin is a fixed time schedule.
  logic [DEB:0] hq = '0, hh = '0;
  bit cq = 0, ch = 0, pq = 0, ph = 0;
  bit m_idle = 1, m_rej = 0, code_q = 0, code_h = 0;
  int age = 0;
  bit e_q = 0, e_h = 0, e_clkb = 1, e_busy = 0, e_rej = 0;
  int e_cnt = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      hq = '0; hh = '0; cq = 0; ch = 0; pq = 0; ph = 0;
      m_idle = 1; m_rej = 0; code_q = 0; code_h = 0; age = 0;
      e_q = 0; e_h = 0; e_clkb = 1; e_busy = 0; e_rej = 0; e_cnt = 0;
    end else begin
      bit ev_q, ev_h;
      ev_q  = cq && !pq;
      ev_h  = ch && !ph;
      e_rej = 0;
      if (m_idle) begin
        if (ev_q && ev_h) begin
          m_idle = 0; m_rej = 1; age = 0; e_rej = 1;
        end else if (ev_q || ev_h) begin
          m_idle = 0; m_rej = 0; age = 0; code_q = ev_q; code_h = ev_h;
        end
      end else begin
        age++;
        if ((m_rej || age >= TXN + 1) && !cq && !ch) m_idle = 1;
        else if (!m_rej && age == int'(S) && e_cnt < 255) e_cnt++;
      end
      e_busy = !m_idle;
      e_q    = !m_idle && !m_rej && code_q && age < TXN;
      e_h    = !m_idle && !m_rej && code_h && age < TXN;
      e_clkb = !(!m_idle && !m_rej && age >= int'(S) && age < int'(S + P));
      pq = cq;
      ph = ch;
      if (hq[DEB:1] == '1) cq = 1; else if (hq[DEB:1] == '0) cq = 0;
      if (hh[DEB:1] == '1) ch = 1; else if (hh[DEB:1] == '0) ch = 0;
      hq = {hq[DEB-1:0], q_in};
      hh = {hh[DEB-1:0], h_in};
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("model_Q", int'(Q), int'(e_q));
      chk("model_H", int'(H), int'(e_h));
      chk("model_CLKb", int'(CLKb), int'(e_clkb));
      chk("model_busy", int'(busy), int'(e_busy));
      chk("model_reject", int'(reject), int'(e_rej));
      chk("model_coin_count", int'(coin_count), e_cnt);
    end
  end

  int n_str = 0;
  int n_rej = 0;
  bit q_seen = 0, h_seen = 0;
  initial forever begin
    @(negedge CLKb);
    n_str++;
  end
  initial forever begin
    @(negedge clk);
    if (reject === 1'b1) n_rej++;
    if (Q === 1'b1) q_seen = 1;
    if (H === 1'b1) h_seen = 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 0;
    q_in = 0;
    h_in = 0;
    cyc(3);
    @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
  endtask

  task automatic wait_strobe(string name);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (CLKb == 1'b0) ok = 1;
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic wait_idle(string name);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (busy == 1'b0) ok = 1;
    end
    chk(name, int'(ok), 1);
  endtask

  initial begin
    int s0, r0, lat;
    bit found;
    logic [9:0] qt, ct;

    // Reset values while RES is held low
    cyc(3);
    chk("rst_Q", int'(Q), 0);
    chk("rst_H", int'(H), 0);
    chk("rst_CLKb", int'(CLKb), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_count", int'(coin_count), 0);
    @(posedge clk);
    #2 rst_n = 1;
    cmp_en = 1;
    cyc(2);

    // Single quarter: latency, code/strobe timing
    q_in = 1;
    found = 0;
    lat = 0;
    for (int i = 1; i <= 30 && !found; i++) begin
      @(negedge clk);
      if (Q) begin found = 1; lat = i; end
    end
    chk("t1_latency", lat, 7);
    qt = '0;
    ct = '0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      qt[9-i] = Q;
      ct[9-i] = CLKb;
    end
    chk("t1_q_trace", int'(qt), int'(10'b1111111000));
    chk("t1_clkb_trace", int'(ct), int'(10'b1100011111));
    cyc(4);
    q_in = 0;
    chk("t1_count", int'(coin_count), 1);
    wait_idle("t1_idle");

    // Bouncing half-dollar never settles
    do_reset();
    s0 = n_str;
    for (int i = 0; i < 16; i++) begin
      h_in = ((i / 2) % 2) == 0;
      @(negedge clk);
    end
    h_in = 0;
    cyc(10);
    chk("t2_strobes", n_str - s0, 0);
    chk("t2_count", int'(coin_count), 0);
    chk("t2_busy", int'(busy), 0);

    // Simultaneous insertion is rejected
    do_reset();
    s0 = n_str;
    r0 = n_rej;
    q_in = 1;
    h_in = 1;
    cyc(10);
    chk("t3_reject_pulses", n_rej - r0, 1);
    chk("t3_busy_held", int'(busy), 1);
    q_in = 0;
    h_in = 0;
    wait_idle("t3_busy_drop");
    chk("t3_strobes", n_str - s0, 0);
    chk("t3_count", int'(coin_count), 0);

    // Quarter arriving mid-transaction is ignored
    do_reset();
    s0 = n_str;
    q_seen = 0;
    h_seen = 0;
    h_in = 1;
    wait_strobe("t4_strobe");
    q_in = 1;
    cyc(6);
    q_in = 0;
    cyc(10);
    h_in = 0;
    wait_idle("t4_idle");
    cyc(12);
    chk("t4_strobes", n_str - s0, 1);
    chk("t4_q_seen", int'(q_seen), 0);
    chk("t4_h_seen", int'(h_seen), 1);
    chk("t4_count", int'(coin_count), 1);

    // Reset in the second STEP cycle releases CLKb at once
    do_reset();
    q_in = 1;
    wait_strobe("t5_strobe");
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t5_CLKb", int'(CLKb), 1);
    chk("t5_Q", int'(Q), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_count", int'(coin_count), 0);
    q_in = 0;
    cyc(2);
    s0 = n_str;
    @(posedge clk);
    #2 rst_n = 1;
    cyc(20);
    chk("t5_no_resume", n_str - s0, 0);

    // Switch held through reset counts once after release
    @(negedge clk);
    #1 rst_n = 0;
    q_in = 1;
    cyc(3);
    s0 = n_str;
    @(posedge clk);
    #2 rst_n = 1;
    cyc(20);
    chk("t5b_strobes", n_str - s0, 1);
    chk("t5b_count", int'(coin_count), 1);
    q_in = 0;
    wait_idle("t5b_idle");

    // Saturation of coin_count
    do_reset();
    s0 = n_str;
    for (int i = 0; i < 260; i++) begin
      if ($urandom_range(0, 1) == 1) q_in = 1; else h_in = 1;
      cyc(10);
      q_in = 0;
      h_in = 0;
      cyc(10);
    end
    cyc(10);
    chk("t6_strobes", n_str - s0, 260);
    chk("t6_count", int'(coin_count), 255);

    // Random levels and dwell times, one asynchronous reset thrown in
    do_reset();
    for (int i = 0; i < 300; i++) begin
      q_in = 1'($urandom_range(0, 1));
      h_in = 1'($urandom_range(0, 1));
      if (i == 150) begin
        @(negedge clk);
        #($urandom_range(1, 4)) rst_n = 0;
        @(negedge clk);
        #2 rst_n = 1;
      end
      cyc($urandom_range(1, 12));
    end
    q_in = 0;
    h_in = 0;
    cyc(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
